// File: rtl/aurora_ll_pkg.sv
// Definitions shared by the Aurora LocalLink TX feeder and the RX-side FIFO writer.
package aurora_ll_pkg;

  typedef enum logic [1:0] {
    S_DOWN    = 2'd0,
    S_HOLDOFF = 2'd1,
    S_RUN     = 2'd2
  } ll_state_e;

  localparam int unsigned LlWidth    = 32;
  localparam int unsigned LlCntWidth = 32;

  // LocalLink handshakes are active low.
  localparam logic LlRdyAsserted   = 1'b0;
  localparam logic LlRdyDeasserted = 1'b1;

endpackage

// File: rtl/tx_skid_buf.sv
// Two-entry buffer absorbing the one-cycle FIFO read latency; entry 0 is always the head.
module tx_skid_buf #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o,
  output logic [1:0]       occ_o
);

  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (occ_q == 2'd0) head_d = din_i;
          else               tail_d = din_i;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          tail_d = '0;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the incoming word lands behind whatever remains.
          if (occ_q == 2'd1) begin
            head_d = din_i;
          end else begin
            head_d = tail_q;
            tail_d = din_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign dout_o = (occ_q == 2'd0) ? '0 : head_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/tx_control.sv
// Drains a standard-latency FIFO into the Aurora LocalLink TX interface, with link-up holdoff,
// back-pressure absorption and flush-on-link-loss.
module tx_control
  import aurora_ll_pkg::*;
#(
  parameter int unsigned WIDTH     = LlWidth,
  parameter int unsigned HOLDOFF   = 16,
  parameter int unsigned CNT_WIDTH = LlCntWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 link_active,
  input  logic [WIDTH-1:0]     fifo_data_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rden_o,
  output logic [WIDTH-1:0]     tx_d,
  output logic                 tx_src_rdy_n,
  input  logic                 tx_dst_rdy_n,
  output logic [CNT_WIDTH-1:0] tx_word_count_o,
  output logic [CNT_WIDTH-1:0] drop_count_o
);

  localparam int unsigned HoldW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int unsigned SumW  = CNT_WIDTH + 1;

  ll_state_e            state_q, state_d;
  logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;
  logic                 rd_pending_q, rd_pending_d;
  logic [CNT_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic [1:0]    occ;
  logic          run, xfer, flush;
  logic [2:0]    in_flight;
  logic [SumW-1:0] drop_sum;

  assign run          = (state_q == S_RUN) && link_active;
  assign flush        = !link_active;
  assign tx_src_rdy_n = (run && (occ != 2'd0)) ? LlRdyAsserted : LlRdyDeasserted;
  assign xfer         = (tx_src_rdy_n == LlRdyAsserted) && (tx_dst_rdy_n == LlRdyAsserted);
  // A word leaving this cycle frees its slot for a read issued in the same cycle.
  assign in_flight    = {1'b0, occ} + {2'b00, rd_pending_q} - {2'b00, xfer};
  assign fifo_rden_o  = run && !fifo_empty_i && (in_flight < 3'd2);

  tx_skid_buf #(
    .Width (WIDTH)
  ) u_skid (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (rd_pending_q),
    .pop_i   (xfer),
    .flush_i (flush),
    .din_i   (fifo_data_i),
    .dout_o  (tx_d),
    .occ_o   (occ)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (!link_active) begin
      state_d    = S_DOWN;
      hold_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_DOWN: begin
          state_d    = (HOLDOFF == 0) ? S_RUN : S_HOLDOFF;
          hold_cnt_d = '0;
        end
        S_HOLDOFF: begin
          if (32'(hold_cnt_q) == HOLDOFF - 32'd1) begin
            state_d    = S_RUN;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
        end
        S_RUN: ;
        default: state_d = S_DOWN;
      endcase
    end
  end

  always_comb begin
    rd_pending_d = fifo_rden_o;
    tx_cnt_d     = tx_cnt_q + CNT_WIDTH'(xfer);
    drop_sum     = {1'b0, drop_cnt_q} + SumW'(occ) + SumW'(rd_pending_q);
    drop_cnt_d   = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_DOWN;
      hold_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
      tx_cnt_q     <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      rd_pending_q <= rd_pending_d;
      tx_cnt_q     <= tx_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign tx_word_count_o = tx_cnt_q;
  assign drop_count_o    = drop_cnt_q;

endmodule

// File: tb/tb_tx_control.sv
// Randomised bench for tx_control: a FIFO emulator, an in-flight word model and scenario tasks.
module tb_tx_control;

  localparam int unsigned HOLDOFF = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        link_active = 1'b0;
  logic [31:0] fifo_data = '0;
  logic        fifo_empty;
  logic        tx_dst_rdy_n = 1'b1;

  logic        fifo_rden, tx_src_rdy_n;
  logic [31:0] tx_d, txc, dropc;
  logic        fifo_rden_s, tx_src_rdy_n_s;
  logic [31:0] tx_d_s;
  logic [3:0]  txc_s, dropc_s;

  always #5 clk = ~clk;

  tx_control #(.WIDTH(32), .HOLDOFF(HOLDOFF), .CNT_WIDTH(32)) dut (
    .clk (clk), .rst (rst), .link_active (link_active),
    .fifo_data_i (fifo_data), .fifo_empty_i (fifo_empty), .fifo_rden_o (fifo_rden),
    .tx_d (tx_d), .tx_src_rdy_n (tx_src_rdy_n), .tx_dst_rdy_n (tx_dst_rdy_n),
    .tx_word_count_o (txc), .drop_count_o (dropc)
  );

  // Narrow-counter twin fed identically; only its counters should differ.
  tx_control #(.WIDTH(32), .HOLDOFF(HOLDOFF), .CNT_WIDTH(4)) dut_s (
    .clk (clk), .rst (rst), .link_active (link_active),
    .fifo_data_i (fifo_data), .fifo_empty_i (fifo_empty), .fifo_rden_o (fifo_rden_s),
    .tx_d (tx_d_s), .tx_src_rdy_n (tx_src_rdy_n_s), .tx_dst_rdy_n (tx_dst_rdy_n),
    .tx_word_count_o (txc_s), .drop_count_o (dropc_s)
  );

  // FIFO emulator: data appears the cycle after the read enable.
  logic [31:0] mem [0:1023];
  int pushed = 0;
  int popped = 0;
  assign fifo_empty = (pushed == popped);

  always @(posedge clk) begin
    if (fifo_rden) begin
      fifo_data <= mem[popped % 1024];
      popped    <= popped + 1;
    end
  end

  // Reference model: words read but not yet accepted, in order.
  logic [31:0] q[$];
  int rd_idx = 0;
  int exp_tx = 0;
  int exp_drop = 0;
  int viol = 0;
  int k = 0;

  always @(negedge clk) begin
    if (fifo_rden_s !== fifo_rden || tx_d_s !== tx_d || tx_src_rdy_n_s !== tx_src_rdy_n) viol++;
    if (rst) begin
      q.delete();
      exp_tx = 0;
      exp_drop = 0;
      k = 0;
      if (fifo_rden) rd_idx++;
    end else if (!link_active) begin
      k = 0;
      if (fifo_rden !== 1'b0 || tx_src_rdy_n !== 1'b1) viol++;
      exp_drop += q.size();
      q.delete();
    end else begin
      k++;
      if (k < int'(HOLDOFF) + 2 && (fifo_rden || !tx_src_rdy_n)) viol++;
      if (fifo_rden && fifo_empty) viol++;
      if (tx_src_rdy_n === 1'b0) begin
        if (q.size() == 0 || tx_d !== q[0]) viol++;
        else if (tx_dst_rdy_n === 1'b0) begin
          void'(q.pop_front());
          exp_tx++;
        end
      end
      if (fifo_rden) begin
        q.push_back(mem[rd_idx % 1024]);
        rd_idx++;
      end
      if (q.size() > 2) viol++;
    end
  end

  int total = 0;
  int bad = 0;
  int base3 = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[pushed % 1024] = w;
    pushed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; link_active = 1'b0; tx_dst_rdy_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    total++; if (fifo_rden !== 1'b0) begin bad++; $display("FAIL reset_rden got=%b want=0", fifo_rden); end
    total++; if (tx_d !== 32'd0) begin bad++; $display("FAIL reset_tx_d got=%h want=0", tx_d); end
    total++; if (tx_src_rdy_n !== 1'b1) begin bad++; $display("FAIL reset_src got=%b want=1", tx_src_rdy_n); end
    total++; if (txc !== 32'd0 || txc_s !== 4'd0) begin bad++; $display("FAIL reset_txc got=%0d/%0d want=0", txc, txc_s); end
    total++; if (dropc !== 32'd0 || dropc_s !== 4'd0) begin bad++; $display("FAIL reset_drop got=%0d/%0d want=0", dropc, dropc_s); end
  endtask

  task automatic test_holdoff();
    int first_rd, n;
    int xc[4];
    logic [31:0] xd[4];
    for (int i = 0; i < 4; i++) push_word(32'hA0 + i);
    tick(); rst = 1'b0; link_active = 1'b1; tx_dst_rdy_n = 1'b0;
    first_rd = 0; n = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (fifo_rden && first_rd == 0) first_rd = c;
      if (!tx_src_rdy_n && !tx_dst_rdy_n) begin
        if (n < 4) begin xc[n] = c; xd[n] = tx_d; end
        n++;
      end
    end
    total++; if (first_rd != int'(HOLDOFF) + 2) begin bad++; $display("FAIL holdoff_first_rden got=%0d want=%0d", first_rd, HOLDOFF + 2); end
    total++; if (n != 4) begin bad++; $display("FAIL holdoff_nwords got=%0d want=4", n); end
    for (int j = 0; j < 4 && j < n; j++) begin
      total++; if (xc[j] != int'(HOLDOFF) + 4 + j || xd[j] !== 32'hA0 + j) begin
        bad++; $display("FAIL holdoff_word%0d got=%h@%0d want=%h@%0d", j, xd[j], xc[j], 32'hA0 + j, HOLDOFF + 4 + j);
      end
    end
    tick(); @(negedge clk);
    total++; if (txc !== 32'd4 || dropc !== 32'd0) begin bad++; $display("FAIL holdoff_counts got=%0d/%0d want=4/0", txc, dropc); end
  endtask

  task automatic test_stream();
    int n;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    for (int i = 0; i < 100; i++) push_word($urandom);
    n = 0;
    for (int c = 0; c < 2000 && n < 100; c++) begin
      tick(); tx_dst_rdy_n = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!tx_src_rdy_n && !tx_dst_rdy_n) n++;
    end
    tick(); tx_dst_rdy_n = 1'b0;
    @(negedge clk);
    total++; if (n != 100 || exp_tx != 100) begin bad++; $display("FAIL stream_accepted got=%0d model=%0d want=100", n, exp_tx); end
    total++; if (txc !== 32'd100) begin bad++; $display("FAIL stream_txc got=%0d want=100", txc); end
    total++; if (txc_s !== 4'd4) begin bad++; $display("FAIL stream_txc_narrow got=%0d want=4", txc_s); end
    total++; if (dropc !== 32'd0) begin bad++; $display("FAIL stream_drop got=%0d want=0", dropc); end
    total++; if (viol != 0) begin bad++; $display("FAIL stream_model violations=%0d want=0", viol); end
  endtask

  task automatic test_backpressure();
    int pulses, rdy_cycles, wrong;
    tick(); tx_dst_rdy_n = 1'b1;
    base3 = pushed;
    for (int i = 0; i < 8; i++) push_word($urandom);
    pulses = 0; rdy_cycles = 0; wrong = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (fifo_rden) pulses++;
      if (!tx_src_rdy_n) begin
        rdy_cycles++;
        if (tx_d !== mem[base3 % 1024]) wrong++;
      end
      tick();
    end
    total++; if (pulses != 2) begin bad++; $display("FAIL bp_rden_pulses got=%0d want=2", pulses); end
    total++; if (rdy_cycles != 48) begin bad++; $display("FAIL bp_src_cycles got=%0d want=48", rdy_cycles); end
    total++; if (wrong != 0) begin bad++; $display("FAIL bp_head_stable bad_cycles=%0d want=0", wrong); end
  endtask

  task automatic test_link_loss();
    int first_rd, first_x;
    logic [31:0] first_d;
    link_active = 1'b0;
    @(negedge clk);
    total++; if (tx_src_rdy_n !== 1'b1 || fifo_rden !== 1'b0) begin
      bad++; $display("FAIL loss_same_cycle got src=%b rden=%b want src=1 rden=0", tx_src_rdy_n, fifo_rden);
    end
    tick(); @(negedge clk);
    total++; if (dropc !== 32'd2 || dropc_s !== 4'd2) begin bad++; $display("FAIL loss_drop got=%0d/%0d want=2", dropc, dropc_s); end
    tick(); link_active = 1'b1; tx_dst_rdy_n = 1'b0;
    first_rd = 0; first_x = 0; first_d = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (fifo_rden && first_rd == 0) first_rd = c;
      if (!tx_src_rdy_n && first_x == 0) begin first_x = c; first_d = tx_d; end
      if (c < 40) tick();
    end
    total++; if (first_rd != int'(HOLDOFF) + 2) begin bad++; $display("FAIL relink_first_rden got=%0d want=%0d", first_rd, HOLDOFF + 2); end
    total++; if (first_x != int'(HOLDOFF) + 4 || first_d !== mem[(base3 + 2) % 1024]) begin
      bad++; $display("FAIL relink_first_word got=%h@%0d want=%h@%0d", first_d, first_x, mem[(base3 + 2) % 1024], HOLDOFF + 4);
    end
    total++; if (pushed != popped || q.size() != 0 || viol != 0) begin
      bad++; $display("FAIL relink_drain left=%0d inflight=%0d violations=%0d want=0", pushed - popped, q.size(), viol);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) push_word($urandom);
    repeat (5) tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    total++; if (fifo_rden !== 1'b0 || tx_src_rdy_n !== 1'b1 || tx_d !== 32'd0) begin
      bad++; $display("FAIL midrst_outputs got rden=%b src=%b d=%h want 0/1/0", fifo_rden, tx_src_rdy_n, tx_d);
    end
    total++; if (txc !== 32'd0 || dropc !== 32'd0 || txc_s !== 4'd0 || dropc_s !== 4'd0) begin
      bad++; $display("FAIL midrst_counts got=%0d/%0d/%0d/%0d want=0", txc, dropc, txc_s, dropc_s);
    end
  endtask

  task automatic test_wrap_sat();
    repeat (60) tick();
    total++; if (pushed != popped || viol != 0) begin bad++; $display("FAIL wrap_predrain left=%0d violations=%0d want=0", pushed - popped, viol); end
    rst = 1'b1;
    tick(); rst = 1'b0;
    for (int i = 0; i < 15; i++) push_word($urandom);
    repeat (50) tick();
    @(negedge clk);
    total++; if (txc_s !== 4'd15 || txc !== 32'd15) begin bad++; $display("FAIL wrap_at_max got=%0d/%0d want=15/15", txc_s, txc); end
    tick(); push_word($urandom);
    repeat (5) tick();
    @(negedge clk);
    total++; if (txc_s !== 4'd0 || txc !== 32'd16) begin bad++; $display("FAIL wrap_to_zero got=%0d/%0d want=0/16", txc_s, txc); end
    for (int it = 0; it < 9; it++) begin
      tick(); link_active = 1'b0; tx_dst_rdy_n = 1'b1;
      for (int i = 0; i < 3; i++) push_word($urandom);
      tick(); link_active = 1'b1;
      @(negedge clk);
      if (it == 8) begin
        total++; if (dropc !== 32'd16 || dropc_s !== 4'd15) begin bad++; $display("FAIL sat_drop16 got=%0d/%0d want=16/15", dropc, dropc_s); end
      end
      repeat (24) tick();
    end
    tick(); link_active = 1'b0;
    tick(); link_active = 1'b1;
    @(negedge clk);
    total++; if (dropc !== 32'd18 || dropc_s !== 4'd15) begin bad++; $display("FAIL sat_drop18 got=%0d/%0d want=18/15", dropc, dropc_s); end
    total++; if (exp_drop != 18 || txc !== 32'd16 || viol != 0) begin
      bad++; $display("FAIL sat_model model_drop=%0d txc=%0d violations=%0d want=18/16/0", exp_drop, txc, viol);
    end
  endtask

  initial begin
    test_reset();
    test_holdoff();
    test_stream();
    test_backpressure();
    test_link_loss();
    test_reset_mid();
    test_wrap_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
